mc_host_bridge: RTL and testbench

- Upstream adapter in front of the HyperRAM memory controller's host port.
- Accepts 32-bit word or cache-line requests from the cache/bus side.
- Sends each request to the controller as one host transaction, split into 16-bit halfword beats.
- Reassembles read halfwords into 32-bit words and converts byte enables into per-halfword masks.

---
 rtl/mc_host_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_mc_host_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_host_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_host_bridge                                                     |
// | Turns 32-bit word/line requests into 16-bit HyperRAM host beats.   |
// | Optional performance counters: define MC_BRIDGE_PERF_EN.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mc_host_bridge #(
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = $clog2(2*LINE_WORDS)+1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_req,
  input  logic        up_rwn,
  input  logic        up_line,
  input  logic [31:0] up_adr,
  input  logic [3:0]  up_wen,
  input  logic [31:0] up_wdat,
  output logic        up_wdat_ack,
  output logic [31:0] up_rdat,
  output logic        up_rdat_vld,
  output logic        up_busy,
  output logic        up_done,
  output logic        host_req,
  output logic        host_rwn,
  output logic        host_burst,
  output logic [31:0] host_addr,
  input  logic        host_ack,
  output logic [1:0]  host_txm,
  output logic [15:0] host_txd,
  input  logic        host_txd_ack,
  input  logic [15:0] host_rxd,
  input  logic        host_rxd_vld,
  input  logic        perf_clr,
  output logic [31:0] perf_rd,
  output logic [31:0] perf_wr,
  output logic [31:0] perf_busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [31:0]      LINE_MASK  = ~((32'(LINE_WORDS) << 2) - 32'd1);
  localparam logic [31:0]      WORD_MASK  = 32'hFFFF_FFFC;
  localparam logic [CNT_W-1:0] BEATS_WORD = CNT_W'(2);
  localparam logic [CNT_W-1:0] BEATS_LINE = CNT_W'(2*LINE_WORDS);

  state_t           state;
  state_t           state_nxt;
  logic             rwn_q;
  logic             line_q;
  logic [3:0]       wen_q;
  logic [31:0]      wdat_q;
  logic [31:0]      addr_q;
  logic [31:0]      rdat_q;
  logic [15:0]      low_q;
  logic             rvld_q;
  logic             wack_q;
  logic             load_q;
  logic [CNT_W-1:0] cnt;
  logic             beats_left;
  logic             wr_beat;
  logic             rd_beat;

  // The beat counter runs down from an even value, so its LSB is the
  // halfword select: even count = low half, odd count = high half.
  assign beats_left = (cnt != '0);
  assign wr_beat    = (state == S_WR) && beats_left && host_txd_ack;
  assign rd_beat    = (state == S_RD) && beats_left && host_rxd_vld;

  assign host_rwn    = rwn_q;
  assign host_burst  = line_q;
  assign host_addr   = addr_q;
  assign up_rdat     = rdat_q;
  assign up_rdat_vld = rvld_q;
  assign up_wdat_ack = wack_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    up_busy   = 1'b0;
    up_done   = 1'b0;
    host_req  = 1'b0;
    host_txd  = '0;
    host_txm  = '0;
    case (state)
      S_IDLE: begin
        if (up_req) state_nxt = S_CMD;
      end
      S_CMD: begin
        up_busy  = 1'b1;
        host_req = 1'b1;
        if (host_ack) state_nxt = rwn_q ? S_RD : S_WR;
      end
      S_WR: begin
        up_busy = 1'b1;
        if (beats_left) begin
          host_txd = cnt[0] ? wdat_q[31:16] : wdat_q[15:0];
          host_txm = cnt[0] ? ~wen_q[3:2]   : ~wen_q[1:0];
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_RD: begin
        up_busy = 1'b1;
        if (!beats_left) state_nxt = S_DONE;
      end
      S_DONE: begin
        up_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rwn_q  <= 1'b0;
      line_q <= 1'b0;
      wen_q  <= '0;
      wdat_q <= '0;
      addr_q <= '0;
      rdat_q <= '0;
      low_q  <= '0;
      rvld_q <= 1'b0;
      wack_q <= 1'b0;
      load_q <= 1'b0;
      cnt    <= '0;
    end else begin
      rvld_q <= 1'b0;
      wack_q <= 1'b0;
      // Upstream presents the next word one cycle after the ack pulse.
      load_q <= wack_q;

      if ((state == S_IDLE) && up_req) begin
        rwn_q  <= up_rwn;
        line_q <= up_line;
        wen_q  <= up_wen;
        wdat_q <= up_wdat;
        addr_q <= up_adr & (up_line ? LINE_MASK : WORD_MASK);
        cnt    <= up_line ? BEATS_LINE : BEATS_WORD;
      end

      if (wr_beat) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt[0]) wack_q <= 1'b1;
      end

      if (load_q && (state == S_WR)) begin
        wdat_q <= up_wdat;
        wen_q  <= up_wen;
      end

      if (rd_beat) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt[0]) begin
          rdat_q <= {host_rxd, low_q};
          rvld_q <= 1'b1;
        end else begin
          low_q <= host_rxd;
        end
      end
    end
  end

`ifdef MC_BRIDGE_PERF_EN
  logic [31:0] perf_rd_q;
  logic [31:0] perf_wr_q;
  logic [31:0] perf_busy_q;

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      perf_rd_q   <= '0;
      perf_wr_q   <= '0;
      perf_busy_q <= '0;
    end else begin
      if (up_done && rwn_q)  perf_rd_q <= perf_rd_q + 32'd1;
      if (up_done && !rwn_q) perf_wr_q <= perf_wr_q + 32'd1;
      if (up_busy)           perf_busy_q <= perf_busy_q + 32'd1;
    end
  end

  assign perf_rd   = perf_rd_q;
  assign perf_wr   = perf_wr_q;
  assign perf_busy = perf_busy_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_rd   = '0;
  assign perf_wr   = '0;
  assign perf_busy = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_host_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for mc_host_bridge: stimulus pushes expectations,
// an independent monitor pops and compares whenever the DUT emits.
module tb_mc_host_bridge;
  localparam int LW = 8;
`ifdef MC_BRIDGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up_req = 1'b0, up_rwn = 1'b0, up_line = 1'b0;
  logic [31:0] up_adr = '0, up_wdat = '0;
  logic [3:0]  up_wen = '0;
  logic        up_wdat_ack, up_rdat_vld, up_busy, up_done;
  logic [31:0] up_rdat;
  logic        host_req, host_rwn, host_burst;
  logic [31:0] host_addr;
  logic        host_ack = 1'b0, host_txd_ack = 1'b0, host_rxd_vld = 1'b0;
  logic [1:0]  host_txm;
  logic [15:0] host_txd;
  logic [15:0] host_rxd = '0;
  logic        perf_clr = 1'b0;
  logic [31:0] perf_rd, perf_wr, perf_busy;

  mc_host_bridge #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .up_req(up_req), .up_rwn(up_rwn), .up_line(up_line), .up_adr(up_adr),
    .up_wen(up_wen), .up_wdat(up_wdat), .up_wdat_ack(up_wdat_ack),
    .up_rdat(up_rdat), .up_rdat_vld(up_rdat_vld), .up_busy(up_busy), .up_done(up_done),
    .host_req(host_req), .host_rwn(host_rwn), .host_burst(host_burst),
    .host_addr(host_addr), .host_ack(host_ack), .host_txm(host_txm),
    .host_txd(host_txd), .host_txd_ack(host_txd_ack), .host_rxd(host_rxd),
    .host_rxd_vld(host_rxd_vld), .perf_clr(perf_clr),
    .perf_rd(perf_rd), .perf_wr(perf_wr), .perf_busy(perf_busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic rwn; logic burst; } cmd_t;
  typedef struct { logic rwn; int nack; } done_t;

  cmd_t        cmd_q[$];
  logic [17:0] beat_q[$];
  logic [31:0] rd_q[$];
  done_t       done_q[$];
  logic [31:0] fix_w[$];
  logic [15:0] fix_h[$];
  logic [31:0] cur_words[$];

  int n_tests = 0, n_fail = 0;
  int wack_cnt = 0, wack_seen = 0;
  int rd_model = 0, wr_model = 0, busy_model = 0;
  int cyc = 0, last_pulse_cyc = 0;
  bit beat_chk = 1'b0, stray_req = 1'b0;
  logic prev_req = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_up_busy"},     up_busy, 0);
    chk({tag, "_up_done"},     up_done, 0);
    chk({tag, "_up_wdat_ack"}, up_wdat_ack, 0);
    chk({tag, "_up_rdat"},     up_rdat, 0);
    chk({tag, "_up_rdat_vld"}, up_rdat_vld, 0);
    chk({tag, "_host_req"},    host_req, 0);
    chk({tag, "_host_addr"},   {host_rwn, host_burst, host_addr}, 0);
    chk({tag, "_host_txd"},    {host_txm, host_txd}, 0);
    chk({tag, "_perf"},        {perf_rd, perf_wr} | 64'(perf_busy), 0);
  endtask

  task automatic chk_perf(input string tag);
    chk({tag, "_perf_rd"},   perf_rd,   PERF ? rd_model   : 0);
    chk({tag, "_perf_wr"},   perf_wr,   PERF ? wr_model   : 0);
    chk({tag, "_perf_busy"}, perf_busy, PERF ? busy_model : 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    cmd_t c;
    done_t d;
    logic [17:0] b;
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (rst) begin
        busy_model = 0; rd_model = 0; wr_model = 0;
        prev_req = host_req;
        continue;
      end
      if (up_busy) busy_model++;
      if (host_req && !prev_req) begin
        chk("cmd_expected", cmd_q.size() > 0, 1);
        if (cmd_q.size() > 0) begin
          c = cmd_q.pop_front();
          chk("host_addr",  host_addr,  c.addr);
          chk("host_rwn",   host_rwn,   c.rwn);
          chk("host_burst", host_burst, c.burst);
        end
      end
      prev_req = host_req;
      if (beat_chk) begin
        chk("beat_expected", beat_q.size() > 0, 1);
        if (beat_q.size() > 0) begin
          b = beat_q.pop_front();
          chk("host_txd", host_txd, b[17:2]);
          chk("host_txm", host_txm, b[1:0]);
        end
      end
      if (up_rdat_vld) begin
        last_pulse_cyc = cyc;
        chk("rdat_expected", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) chk("up_rdat", up_rdat, rd_q.pop_front());
      end
      if (up_wdat_ack) begin
        wack_cnt++;
        last_pulse_cyc = cyc;
      end
      if (up_done) begin
        chk("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          d = done_q.pop_front();
          chk("wdat_ack_count", wack_cnt, d.nack);
          chk("done_latency", cyc - last_pulse_cyc, 1);
          if (d.rwn) rd_model++; else wr_model++;
        end
        wack_cnt = 0;
      end
    end
  end

  // Upstream write-data source: next word valid the cycle after each ack pulse.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (up_wdat_ack && !rst) begin
        wack_seen++;
        @(posedge clk); #1;
        if (wack_seen < cur_words.size()) up_wdat = cur_words[wack_seen];
      end
    end
  end

  task automatic wait_done(input logic clr);
    int t = 0;
    while (!up_done && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("up_done_seen", up_done, 1);
    if (clr) perf_clr = 1'b1;
    @(posedge clk); #1;
    if (clr) begin
      perf_clr = 1'b0;
      chk("clr_with_done_perf_rd",   perf_rd,   0);
      chk("clr_with_done_perf_wr",   perf_wr,   0);
      chk("clr_with_done_perf_busy", perf_busy, 0);
      rd_model = 0; wr_model = 0; busy_model = 0;
    end
  endtask

  // Controller model: accepts the command, then consumes/produces halfwords.
  task automatic ctl_run(input logic rwn, input int nb, input logic [15:0] hws[$], input int abort_after);
    int t = 0;
    int k;
    while (!host_req && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("host_req_seen", host_req, 1);
    if (!host_req) return;
    k = $urandom_range(0, 3);
    if (stray_req && k == 0) k = 1;
    repeat (k) begin
      up_req = stray_req;
      @(posedge clk); #1;
      up_req = 1'b0;
    end
    host_ack = 1'b1;
    @(posedge clk); #1;
    host_ack = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (rwn) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        host_rxd = hws[i];
        host_rxd_vld = 1'b1;
        @(posedge clk); #1;
        host_rxd_vld = 1'b0;
        host_rxd = 16'($urandom());
      end else begin
        repeat ($urandom_range(2, 4)) begin @(posedge clk); #1; end
        host_txd_ack = 1'b1;
        beat_chk = 1'b1;
        @(posedge clk); #1;
        host_txd_ack = 1'b0;
        beat_chk = 1'b0;
        if (i == abort_after) begin
          rst = 1'b1;
          @(posedge clk); #1;
          check_zero("abort");
          rst = 1'b0;
          beat_q.delete();
          wack_cnt = 0;
          return;
        end
      end
    end
  endtask

  // Reference model: lowest address first, [15:0] first, 1 = masked byte.
  task automatic do_txn(input logic rwn, input logic line, input logic [31:0] adr,
                        input logic [3:0] wen, input int abort_after, input logic clr_done);
    int nw;
    logic [31:0] span, w;
    logic [15:0] lo, hi;
    logic [15:0] hws[$];
    cmd_t  c;
    done_t d;
    nw = line ? LW : 1;
    span = line ? 32'(LW * 4) : 32'd4;
    c.addr = adr - (adr % span);
    c.rwn = rwn;
    c.burst = line;
    cmd_q.push_back(c);
    cur_words.delete();
    for (int i = 0; i < nw; i++) begin
      if (rwn) begin
        if (fix_h.size() > 0) lo = fix_h.pop_front(); else lo = 16'($urandom());
        if (fix_h.size() > 0) hi = fix_h.pop_front(); else hi = 16'($urandom());
        hws.push_back(lo);
        hws.push_back(hi);
        rd_q.push_back({hi, lo});
      end else begin
        if (fix_w.size() > 0) w = fix_w.pop_front(); else w = $urandom();
        cur_words.push_back(w);
        beat_q.push_back({w[15:0],  !wen[1], !wen[0]});
        beat_q.push_back({w[31:16], !wen[3], !wen[2]});
      end
    end
    if (abort_after < 0) begin
      d.rwn = rwn;
      d.nack = rwn ? 0 : nw;
      done_q.push_back(d);
    end
    wack_seen = 0;
    up_rwn = rwn; up_line = line; up_adr = adr; up_wen = wen;
    if (rwn) up_wdat = $urandom(); else up_wdat = cur_words[0];
    up_req = 1'b1;
    @(posedge clk); #1;
    up_req = 1'b0;
    ctl_run(rwn, 2 * nw, hws, abort_after);
    if (abort_after < 0) wait_done(clr_done);
  endtask

  initial begin
    #1ms;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       r, l;
    logic [3:0] we;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    fix_w = '{32'hAABBCCDD};
    do_txn(1'b0, 1'b0, 32'h0000_1006, 4'b0110, -1, 1'b0);
    fix_h = '{16'h1234, 16'h5678};
    do_txn(1'b1, 1'b0, 32'h0000_0020, 4'hF, -1, 1'b0);
    do_txn(1'b1, 1'b1, 32'h0000_004C, 4'hF, -1, 1'b0);
    do_txn(1'b0, 1'b1, 32'h0000_0210, 4'hF, -1, 1'b0);
    do_txn(1'b0, 1'b1, 32'h0000_0300, 4'hF, 3, 1'b0);
    @(posedge clk); #1;
    do_txn(1'b0, 1'b0, 32'h0000_0044, 4'b1001, -1, 1'b0);

    host_ack = 1'b1; host_txd_ack = 1'b1; host_rxd_vld = 1'b1;
    @(posedge clk); #1;
    host_ack = 1'b0; host_txd_ack = 1'b0; host_rxd_vld = 1'b0;
    @(posedge clk); #1;
    chk("stray_up_busy", up_busy, 0);
    chk("stray_host_req", host_req, 0);
    chk("stray_rdat_vld", up_rdat_vld, 0);

    perf_clr = 1'b1;
    @(posedge clk); #1;
    perf_clr = 1'b0;
    rd_model = 0; wr_model = 0; busy_model = 0;
    do_txn(1'b1, 1'b0, 32'h0000_0100, 4'hF, -1, 1'b0);
    do_txn(1'b1, 1'b1, 32'h0000_0180, 4'hF, -1, 1'b0);
    do_txn(1'b0, 1'b0, 32'h0000_0104, 4'hF, -1, 1'b0);
    chk("perf_rd_two", perf_rd, PERF ? 2 : 0);
    chk("perf_wr_one", perf_wr, PERF ? 1 : 0);
    chk_perf("after3");
    do_txn(1'b1, 1'b0, 32'h0000_0080, 4'hF, -1, 1'b1);

    for (int t = 0; t < 24; t++) begin
      r = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      we = l ? 4'hF : 4'($urandom());
      stray_req = ($urandom_range(0, 3) == 0);
      do_txn(r, l, $urandom(), we, -1, 1'b0);
    end
    stray_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_perf("final");
    chk("cmd_q_empty",  cmd_q.size(),  0);
    chk("beat_q_empty", beat_q.size(), 0);
    chk("rd_q_empty",   rd_q.size(),   0);
    chk("done_q_empty", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
